soc_riscv_data_tracker: RTL and testbench



---
 rtl/soc_riscv_data_tracker.sv | 212 +++++++++++++++++++++
 tb/tb_soc_riscv_data_tracker.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_riscv_data_tracker.sv
// Passive multi-channel data-BIU tracker: pairs responses with queued requests and folds completions into a signature.
// Optional per-channel response timeout watchdog is enabled by defining SOC_RISCV_DATA_TRACKER_TIMEOUT_EN.
module soc_riscv_data_tracker #(
    parameter int              XLEN               = 32,
    parameter int              CHANNELS           = 2,
    parameter int              DEPTH              = 4,
    parameter int              TIMEOUT            = 256,
    parameter logic [XLEN-1:0] ADDRESS_LOWERBOUND = 'h0000_0000,
    parameter logic [XLEN-1:0] ADDRESS_UPPERBOUND = 'hffff_ffff
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [CHANNELS-1:0]                    req_i,
    input  logic [CHANNELS*XLEN-1:0]               adr_i,
    input  logic [CHANNELS*XLEN-1:0]               d_i,
    input  logic [CHANNELS*XLEN-1:0]               q_i,
    input  logic [CHANNELS-1:0]                    we_i,
    input  logic [CHANNELS*3-1:0]                  size_i,
    input  logic [CHANNELS-1:0]                    lock_i,
    input  logic [CHANNELS-1:0]                    ack_i,
    input  logic [CHANNELS-1:0]                    err_i,
    input  logic [CHANNELS-1:0]                    misaligned_i,
    input  logic [CHANNELS-1:0]                    page_fault_i,
    output logic [XLEN-1:0]                        signature_o,
    output logic [31:0]                            txn_count_o,
    output logic [15:0]                            err_count_o,
    output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]  outstanding_o,
    output logic [CHANNELS-1:0]                    overflow_o,
    output logic [CHANNELS-1:0]                    orphan_o,
    output logic [CHANNELS-1:0]                    timeout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("soc_riscv_data_tracker: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    // Queue storage; pointers and occupancy carry all control state, so storage needs no reset.
    logic [XLEN-1:0]     r_q_adr  [CHANNELS][DEPTH];
    logic [XLEN-1:0]     r_q_dat  [CHANNELS][DEPTH];
    logic                r_q_we   [CHANNELS][DEPTH];
    logic [2:0]          r_q_size [CHANNELS][DEPTH];
    logic                r_q_lock [CHANNELS][DEPTH];

    logic [AW-1:0]       r_wptr   [CHANNELS];
    logic [AW-1:0]       r_rptr   [CHANNELS];
    logic [CW-1:0]       r_count  [CHANNELS];
    logic [CHANNELS-1:0] r_overflow;
    logic [CHANNELS-1:0] r_orphan;
    logic [XLEN-1:0]     r_sig;
    logic [31:0]         r_txn;
    logic [15:0]         r_err;

    logic [CHANNELS-1:0] w_resp;
    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_push;
    logic [CHANNELS-1:0] w_pop;
    logic [CHANNELS-1:0] w_drop;
    logic [CHANNELS-1:0] w_orphan_evt;
    logic [CHANNELS-1:0] w_in_win;
    logic [CHANNELS-1:0] w_has_err;
    logic [XLEN-1:0]     w_head_adr   [CHANNELS];
    logic [XLEN-1:0]     w_head_dat   [CHANNELS];
    logic [8:0]          w_tag        [CHANNELS];
    logic [CW-1:0]       w_count_next [CHANNELS];

    logic [XLEN-1:0]     w_sig_next;
    logic [31:0]         w_txn_inc;
    logic [16:0]         w_err_inc;
    logic [16:0]         w_err_sum;
    logic [15:0]         w_err_next;

    // A response only pops an entry pushed on an earlier edge: emptiness uses registered occupancy.
    always_comb begin
        w_resp       = '0;
        w_empty      = '0;
        w_full       = '0;
        w_push       = '0;
        w_pop        = '0;
        w_drop       = '0;
        w_orphan_evt = '0;
        w_in_win     = '0;
        w_has_err    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_resp[c]       = ack_i[c] | err_i[c] | page_fault_i[c];
            w_empty[c]      = (r_count[c] == '0);
            w_full[c]       = (r_count[c] == CW'(DEPTH));
            w_pop[c]        = w_resp[c] & ~w_empty[c];
            w_push[c]       = req_i[c] & (~w_full[c] | w_pop[c]);
            w_drop[c]       = req_i[c] & w_full[c] & ~w_pop[c];
            w_orphan_evt[c] = w_resp[c] & w_empty[c];
            w_head_adr[c]   = r_q_adr[c][r_rptr[c]];
            w_head_dat[c]   = r_q_we[c][r_rptr[c]] ? r_q_dat[c][r_rptr[c]] : q_i[c*XLEN +: XLEN];
            w_tag[c]        = {ack_i[c], err_i[c], misaligned_i[c], page_fault_i[c],
                               r_q_lock[c][r_rptr[c]], r_q_we[c][r_rptr[c]], r_q_size[c][r_rptr[c]]};
            w_in_win[c]     = (w_head_adr[c] > ADDRESS_LOWERBOUND) &&
                              (w_head_adr[c] < ADDRESS_UPPERBOUND);
            w_has_err[c]    = err_i[c] | misaligned_i[c] | page_fault_i[c];
            w_count_next[c] = r_count[c] + CW'(w_push[c]) - CW'(w_pop[c]);
        end
    end

    // Completions within one cycle fold in ascending channel order; the rotate makes order matter.
    always_comb begin
        w_sig_next = r_sig;
        w_txn_inc  = '0;
        w_err_inc  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_pop[c] && w_in_win[c]) begin
                w_sig_next = {w_sig_next[XLEN-2:0], w_sig_next[XLEN-1]} ^ w_head_adr[c] ^
                             w_head_dat[c] ^ XLEN'(w_tag[c]);
                w_txn_inc  = w_txn_inc + 32'd1;
            end
            if (w_pop[c] && w_has_err[c]) begin
                w_err_inc = w_err_inc + 17'd1;
            end
        end
        w_err_sum  = {1'b0, r_err} + w_err_inc;
        w_err_next = (w_err_sum > 17'h0ffff) ? 16'hffff : w_err_sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_push[c]) begin
                r_q_adr[c][r_wptr[c]]  <= adr_i[c*XLEN +: XLEN];
                r_q_dat[c][r_wptr[c]]  <= d_i[c*XLEN +: XLEN];
                r_q_we[c][r_wptr[c]]   <= we_i[c];
                r_q_size[c][r_wptr[c]] <= size_i[c*3 +: 3];
                r_q_lock[c][r_wptr[c]] <= lock_i[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_count[c] <= '0;
            end
            r_overflow <= '0;
            r_orphan   <= '0;
            r_sig      <= '0;
            r_txn      <= '0;
            r_err      <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_push[c]) begin
                    r_wptr[c] <= r_wptr[c] + AW'(1);
                end
                if (w_pop[c]) begin
                    r_rptr[c] <= r_rptr[c] + AW'(1);
                end
                r_count[c] <= w_count_next[c];
            end
            r_overflow <= r_overflow | w_drop;
            r_orphan   <= r_orphan | w_orphan_evt;
            r_sig      <= w_sig_next;
            r_txn      <= r_txn + w_txn_inc;
            r_err      <= w_err_next;
        end
    end

`ifdef SOC_RISCV_DATA_TRACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0]       r_to_cnt [CHANNELS];
    logic [CHANNELS-1:0] r_timeout;

    // The flag rises on the same edge the counter reaches TIMEOUT; the counter then holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timeout <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_to_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_resp[c] || w_empty[c]) begin
                    r_to_cnt[c] <= '0;
                end else if (r_to_cnt[c] != TW'(TIMEOUT)) begin
                    r_to_cnt[c] <= r_to_cnt[c] + TW'(1);
                    if (r_to_cnt[c] == TW'(TIMEOUT - 1)) begin
                        r_timeout[c] <= 1'b1;
                    end
                end
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign timeout_o = '0;
`endif

    always_comb begin
        outstanding_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            outstanding_o[c*CW +: CW] = r_count[c];
        end
    end

    assign signature_o = r_sig;
    assign txn_count_o = r_txn;
    assign err_count_o = r_err;
    assign overflow_o  = r_overflow;
    assign orphan_o    = r_orphan;

endmodule

// File: tb/tb_soc_riscv_data_tracker.sv
// Directed bench for soc_riscv_data_tracker (2 channels, depth 4, TIMEOUT 8).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_soc_riscv_data_tracker;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [63:0] adr_i;
    logic [63:0] d_i;
    logic [63:0] q_i;
    logic [1:0]  we_i;
    logic [5:0]  size_i;
    logic [1:0]  lock_i;
    logic [1:0]  ack_i;
    logic [1:0]  err_i;
    logic [1:0]  misaligned_i;
    logic [1:0]  page_fault_i;
    logic [31:0] signature_o;
    logic [31:0] txn_count_o;
    logic [15:0] err_count_o;
    logic [5:0]  outstanding_o;
    logic [1:0]  overflow_o;
    logic [1:0]  orphan_o;
    logic [1:0]  timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_sig;
    logic [31:0] exp_txn;
    logic [15:0] exp_err;

    soc_riscv_data_tracker #(
        .XLEN               (32),
        .CHANNELS           (2),
        .DEPTH              (4),
        .TIMEOUT            (8),
        .ADDRESS_LOWERBOUND (32'h0000_0000),
        .ADDRESS_UPPERBOUND (32'hffff_ffff)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .adr_i         (adr_i),
        .d_i           (d_i),
        .q_i           (q_i),
        .we_i          (we_i),
        .size_i        (size_i),
        .lock_i        (lock_i),
        .ack_i         (ack_i),
        .err_i         (err_i),
        .misaligned_i  (misaligned_i),
        .page_fault_i  (page_fault_i),
        .signature_o   (signature_o),
        .txn_count_o   (txn_count_o),
        .err_count_o   (err_count_o),
        .outstanding_o (outstanding_o),
        .overflow_o    (overflow_o),
        .orphan_o      (orphan_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference fold: rotate-left by one, then xor address, data and {status, lock, we, size}.
    function automatic logic [31:0] model_fold(input logic [31:0] sig, input logic [31:0] adr,
                                               input logic [31:0] data, input logic [3:0] status,
                                               input logic lock, input logic we, input logic [2:0] size);
        logic [31:0] misc;
        misc = {23'd0, status, lock, we, size};
        return {sig[30:0], sig[31]} ^ adr ^ data ^ misc;
    endfunction

    task automatic clear_inputs();
        req_i        = '0;
        adr_i        = '0;
        d_i          = '0;
        q_i          = '0;
        we_i         = '0;
        size_i       = '0;
        lock_i       = '0;
        ack_i        = '0;
        err_i        = '0;
        misaligned_i = '0;
        page_fault_i = '0;
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_i = 1'b1;
        step();
        step();
        rst_i   = 1'b0;
        exp_sig = '0;
        exp_txn = '0;
        exp_err = '0;
    endtask

    task automatic drive_req(input int ch, input logic [31:0] adr, input logic [31:0] d,
                             input logic we, input logic [2:0] size, input logic lock);
        req_i[ch]           = 1'b1;
        adr_i[ch*32 +: 32]  = adr;
        d_i[ch*32 +: 32]    = d;
        we_i[ch]            = we;
        size_i[ch*3 +: 3]   = size;
        lock_i[ch]          = lock;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (signature_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_sig: got %h expected %h", signature_o, 32'h0);
        end
        n_checks++;
        if (txn_count_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_txn: got %0d expected 0", txn_count_o);
        end
        n_checks++;
        if (err_count_o !== 16'h0) begin
            n_fail++; $display("FAIL reset_err: got %0d expected 0", err_count_o);
        end
        n_checks++;
        if (outstanding_o !== 6'h0) begin
            n_fail++; $display("FAIL reset_outstanding: got %h expected 0", outstanding_o);
        end
        n_checks++;
        if ({overflow_o, orphan_o, timeout_o} !== 6'h0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000", {overflow_o, orphan_o, timeout_o});
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        drive_req(0, 32'h100, 32'hDEAD_BEEF, 1'b1, 3'd2, 1'b0);
        step();
        clear_inputs();
        n_checks++;
        if (outstanding_o[2:0] !== 3'd1) begin
            n_fail++; $display("FAIL single_occ_push: got %0d expected 1", outstanding_o[2:0]);
        end
        ack_i[0] = 1'b1;
        step();
        clear_inputs();
        n_checks++;
        if (outstanding_o[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL single_occ_pop: got %0d expected 0", outstanding_o[2:0]);
        end
        // 0x100 ^ 0xDEADBEEF ^ {1000,0,1,010}=0x10A
        n_checks++;
        if (signature_o !== 32'hDEAD_BEE5) begin
            n_fail++; $display("FAIL single_sig: got %h expected %h", signature_o, 32'hDEAD_BEE5);
        end
        n_checks++;
        if (txn_count_o !== 32'd1) begin
            n_fail++; $display("FAIL single_txn: got %0d expected 1", txn_count_o);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_req(0, 32'h200 + 32'(i * 4), 32'h0, 1'b0, 3'd2, 1'b0);
            step();
            if (i == 3) begin
                n_checks++;
                if (overflow_o[0] !== 1'b0) begin
                    n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow_o[0]);
                end
            end
        end
        clear_inputs();
        n_checks++;
        if (overflow_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow_o[0]);
        end
        n_checks++;
        if (outstanding_o[2:0] !== 3'd4) begin
            n_fail++; $display("FAIL ovf_occ: got %0d expected 4", outstanding_o[2:0]);
        end
        for (int i = 0; i < 4; i++) begin
            ack_i[0]     = 1'b1;
            q_i[31:0]    = 32'h1000 + 32'(i);
            exp_sig      = model_fold(exp_sig, 32'h200 + 32'(i * 4), 32'h1000 + 32'(i), 4'b1000, 1'b0, 1'b0, 3'd2);
            exp_txn      = exp_txn + 32'd1;
            step();
        end
        clear_inputs();
        n_checks++;
        if (outstanding_o[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL ovf_drain_occ: got %0d expected 0", outstanding_o[2:0]);
        end
        n_checks++;
        if (orphan_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL ovf_no_orphan: got %b expected 0", orphan_o[0]);
        end
        n_checks++;
        if (signature_o !== exp_sig) begin
            n_fail++; $display("FAIL ovf_sig: got %h expected %h", signature_o, exp_sig);
        end
        n_checks++;
        if (txn_count_o !== exp_txn) begin
            n_fail++; $display("FAIL ovf_txn: got %0d expected %0d", txn_count_o, exp_txn);
        end
    endtask

    task automatic test_orphan();
        ack_i[1] = 1'b1;
        step();
        clear_inputs();
        n_checks++;
        if (orphan_o !== 2'b10) begin
            n_fail++; $display("FAIL orphan_flag: got %b expected 10", orphan_o);
        end
        n_checks++;
        if (signature_o !== exp_sig) begin
            n_fail++; $display("FAIL orphan_sig: got %h expected %h", signature_o, exp_sig);
        end
        n_checks++;
        if (txn_count_o !== exp_txn) begin
            n_fail++; $display("FAIL orphan_txn: got %0d expected %0d", txn_count_o, exp_txn);
        end
    endtask

    task automatic test_dual_ack();
        drive_req(0, 32'h300, 32'h1111_2222, 1'b1, 3'd2, 1'b1);
        drive_req(1, 32'h400, 32'h0, 1'b0, 3'd0, 1'b0);
        step();
        clear_inputs();
        ack_i      = 2'b11;
        q_i[63:32] = 32'hA5A5_0F0F;
        exp_sig    = model_fold(exp_sig, 32'h300, 32'h1111_2222, 4'b1000, 1'b1, 1'b1, 3'd2);
        exp_sig    = model_fold(exp_sig, 32'h400, 32'hA5A5_0F0F, 4'b1000, 1'b0, 1'b0, 3'd0);
        exp_txn    = exp_txn + 32'd2;
        step();
        clear_inputs();
        n_checks++;
        if (signature_o !== exp_sig) begin
            n_fail++; $display("FAIL dual_sig: got %h expected %h", signature_o, exp_sig);
        end
        n_checks++;
        if (txn_count_o !== exp_txn) begin
            n_fail++; $display("FAIL dual_txn: got %0d expected %0d", txn_count_o, exp_txn);
        end
    endtask

    task automatic test_err_window();
        apply_reset();
        drive_req(0, 32'h0, 32'h0, 1'b0, 3'd2, 1'b0);
        step();
        clear_inputs();
        err_i[0] = 1'b1;
        q_i[31:0] = 32'h1234_5678;
        step();
        clear_inputs();
        n_checks++;
        if (err_count_o !== 16'd1) begin
            n_fail++; $display("FAIL errwin_errcnt: got %0d expected 1", err_count_o);
        end
        n_checks++;
        if (txn_count_o !== 32'd0 || signature_o !== 32'h0) begin
            n_fail++; $display("FAIL errwin_untouched: got txn %0d sig %h expected 0 0", txn_count_o, signature_o);
        end
        drive_req(0, 32'h700, 32'h0, 1'b0, 3'd2, 1'b0);
        step();
        clear_inputs();
        misaligned_i[0] = 1'b1;
        step();
        clear_inputs();
        n_checks++;
        if (outstanding_o[2:0] !== 3'd1 || err_count_o !== 16'd1) begin
            n_fail++; $display("FAIL misaligned_only: got occ %0d err %0d expected 1 1", outstanding_o[2:0], err_count_o);
        end
        ack_i[0]        = 1'b1;
        misaligned_i[0] = 1'b1;
        q_i[31:0]       = 32'h77;
        exp_sig         = model_fold(32'h0, 32'h700, 32'h77, 4'b1010, 1'b0, 1'b0, 3'd2);
        step();
        clear_inputs();
        n_checks++;
        if (err_count_o !== 16'd2 || txn_count_o !== 32'd1) begin
            n_fail++; $display("FAIL ackmis_counts: got err %0d txn %0d expected 2 1", err_count_o, txn_count_o);
        end
        n_checks++;
        if (signature_o !== exp_sig) begin
            n_fail++; $display("FAIL ackmis_sig: got %h expected %h", signature_o, exp_sig);
        end
    endtask

    task automatic test_same_cycle_empty();
        apply_reset();
        drive_req(0, 32'h500, 32'h55, 1'b1, 3'd2, 1'b0);
        ack_i[0] = 1'b1;
        step();
        clear_inputs();
        n_checks++;
        if (orphan_o[0] !== 1'b1 || outstanding_o[2:0] !== 3'd1 || txn_count_o !== 32'd0) begin
            n_fail++; $display("FAIL same_cycle: got orphan %b occ %0d txn %0d expected 1 1 0",
                               orphan_o[0], outstanding_o[2:0], txn_count_o);
        end
        ack_i[0] = 1'b1;
        exp_sig  = model_fold(32'h0, 32'h500, 32'h55, 4'b1000, 1'b0, 1'b1, 3'd2);
        step();
        clear_inputs();
        n_checks++;
        if (signature_o !== exp_sig || txn_count_o !== 32'd1) begin
            n_fail++; $display("FAIL same_cycle_later: got sig %h txn %0d expected %h 1", signature_o, txn_count_o, exp_sig);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_req(1, 32'h600 + 32'(i * 4), 32'h0, 1'b0, 3'd1, 1'b0);
            step();
        end
        drive_req(1, 32'h610, 32'h0, 1'b0, 3'd1, 1'b0);
        ack_i[1]   = 1'b1;
        q_i[63:32] = 32'hAAAA_0000;
        exp_sig    = model_fold(exp_sig, 32'h600, 32'hAAAA_0000, 4'b1000, 1'b0, 1'b0, 3'd1);
        step();
        clear_inputs();
        n_checks++;
        if (outstanding_o[5:3] !== 3'd4 || overflow_o[1] !== 1'b0) begin
            n_fail++; $display("FAIL full_pushpop: got occ %0d ovf %b expected 4 0", outstanding_o[5:3], overflow_o[1]);
        end
        for (int i = 0; i < 4; i++) begin
            ack_i[1]   = 1'b1;
            q_i[63:32] = 32'hB0 + 32'(i);
            exp_sig    = model_fold(exp_sig, 32'h604 + 32'(i * 4), 32'hB0 + 32'(i), 4'b1000, 1'b0, 1'b0, 3'd1);
            step();
        end
        clear_inputs();
        n_checks++;
        if (outstanding_o[5:3] !== 3'd0 || txn_count_o !== 32'd5) begin
            n_fail++; $display("FAIL b2b_drain: got occ %0d txn %0d expected 0 5", outstanding_o[5:3], txn_count_o);
        end
        n_checks++;
        if (signature_o !== exp_sig) begin
            n_fail++; $display("FAIL b2b_sig: got %h expected %h", signature_o, exp_sig);
        end
    endtask

    task automatic test_reset_mid();
        drive_req(1, 32'h800, 32'h0, 1'b0, 3'd2, 1'b0);
        step();
        step();
        clear_inputs();
        rst_i = 1'b1;
        step();
        rst_i    = 1'b0;
        ack_i[1] = 1'b1;
        step();
        clear_inputs();
        n_checks++;
        if (orphan_o[1] !== 1'b1 || outstanding_o !== 6'd0 || txn_count_o !== 32'd0 || signature_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid: got orphan %b occ %h txn %0d sig %h expected 1 0 0 0",
                               orphan_o[1], outstanding_o, txn_count_o, signature_o);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        drive_req(0, 32'h900, 32'h0, 1'b0, 3'd2, 1'b0);
        step();
        clear_inputs();
`ifdef SOC_RISCV_DATA_TRACKER_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            step();
        end
        n_checks++;
        if (timeout_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: got %b expected 0", timeout_o[0]);
        end
        step();
        n_checks++;
        if (timeout_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL timeout_set: got %b expected 1", timeout_o[0]);
        end
        ack_i[0] = 1'b1;
        step();
        clear_inputs();
        n_checks++;
        if (timeout_o[0] !== 1'b1 || outstanding_o[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL timeout_sticky: got flag %b occ %0d expected 1 0", timeout_o[0], outstanding_o[2:0]);
        end
        drive_req(0, 32'h904, 32'h0, 1'b0, 3'd2, 1'b0);
        step();
        clear_inputs();
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        n_checks++;
        if (timeout_o !== 2'b00 || outstanding_o !== 6'd0) begin
            n_fail++; $display("FAIL timeout_reset: got flag %b occ %h expected 00 0", timeout_o, outstanding_o);
        end
`else
        for (int i = 0; i < 10; i++) begin
            step();
        end
        n_checks++;
        if (timeout_o !== 2'b00) begin
            n_fail++; $display("FAIL timeout_disabled: got %b expected 00", timeout_o);
        end
        ack_i[0] = 1'b1;
        step();
        clear_inputs();
`endif
    endtask

    initial begin
        clear_inputs();
        rst_i   = 1'b1;
        exp_sig = '0;
        exp_txn = '0;
        exp_err = '0;
        @(negedge clk_i);
        test_reset();
        test_single_write();
        test_overflow();
        test_orphan();
        test_dual_ack();
        test_err_window();
        test_same_cycle_empty();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
